// File: rtl/result_ascii_tx.sv
// result_ascii_tx
//   Transmit side of the console number interface. Accepts one add/sub
//   result (sum bits S, final carry C5, overflow flag E), converts the
//   value to fixed-width decimal with a shift-add-3 (double dabble) BCD
//   converter, and streams the ASCII digits MS first, optionally followed
//   by a '\n', over a valid/ready byte channel.
//
//   Value converted: E=0 -> {0, S}; E=1 -> {C5, S} (WIDTH+1 bits unsigned).
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   synchronous active-low reset
//   in_valid  in   result present on in_s/in_c5/in_e
//   in_ready  out  block can accept a result (IDLE only, not in the first
//                  cycle after reset)
//   in_s      in   WIDTH-bit sum/difference S
//   in_c5     in   final carry C5
//   in_e      in   overflow flag E
//   tx_data   out  ASCII byte
//   tx_valid  out  tx_data is valid
//   tx_ready  in   sink accepts tx_data this cycle
//   busy      out  high from accept until the last byte handshake completes
module result_ascii_tx #(
    parameter int WIDTH   = 5,
    parameter int DIGITS  = 2,
    parameter int NEWLINE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_s,
    input  logic             in_c5,
    input  logic             in_e,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             busy
);

    localparam int VW = WIDTH + 1;
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(VW) + 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, CONV, EMIT, NL} state_t;

    state_t          state, state_nxt;
    logic            armed;
    logic [CW-1:0]   cnt;
    logic [IW-1:0]   idx;
    logic [VW-1:0]   val;
    logic [BW-1:0]   bcd;
    logic [3:0]      digit;
    logic            accept;
    logic            tx_hs;

    // One double-dabble iteration: correct every BCD digit that would
    // overflow past 9 when doubled, then shift in the next value bit.
    function automatic logic [BW-1:0] dd_step(input logic [BW-1:0] b,
                                              input logic bit_in);
        logic [BW-1:0] a;
        a = b;
        for (int d = 0; d < DIGITS; d++) begin
            if (a[4*d +: 4] >= 4'd5)
                a[4*d +: 4] = a[4*d +: 4] + 4'd3;
        end
        return {a[BW-2:0], bit_in};
    endfunction

    // armed holds in_ready low for the first cycle after reset is released.
    assign in_ready = armed && (state == IDLE);
    assign accept   = in_valid && in_ready;
    assign busy     = (state != IDLE);
    assign tx_hs    = tx_valid && tx_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            armed <= 1'b0;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            armed <= 1'b1;
            if (accept)
                cnt <= '0;
            else if (state == CONV)
                cnt <= cnt + CW'(1);
            if (state == CONV)
                idx <= IW'(DIGITS - 1);
            else if (state == EMIT && tx_hs && idx != '0)
                idx <= idx - IW'(1);
        end
    end

    // Datapath registers carry no reset; they are reloaded on every accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            val <= in_e ? {in_c5, in_s} : {1'b0, in_s};
            bcd <= '0;
        end else if (state == CONV) begin
            bcd <= dd_step(bcd, val[VW-1]);
            val <= {val[VW-2:0], 1'b0};
        end
    end

    always_comb begin
        digit = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i))
                digit = bcd[4*i +: 4];
        end
    end

    // tx_valid/tx_data depend on state only, never on tx_ready.
    always_comb begin
        state_nxt = state;
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        case (state)
            IDLE: begin
                if (accept)
                    state_nxt = CONV;
            end
            CONV: begin
                // cnt runs 0..WIDTH, giving exactly WIDTH+1 shift cycles
                if (cnt == CW'(WIDTH))
                    state_nxt = EMIT;
            end
            EMIT: begin
                tx_valid = 1'b1;
                tx_data  = {4'h3, digit};
                if (tx_ready && idx == '0)
                    state_nxt = (NEWLINE != 0) ? NL : IDLE;
            end
            NL: begin
                tx_valid = 1'b1;
                tx_data  = 8'h0A;
                if (tx_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
